// File: rtl/axil_pkg.sv
// Shared AXI-lite definitions: response codes and the slave's FSM state types.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_COLLECT, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_VALID}   rd_state_e;

endpackage

// File: rtl/axil_if.sv
// AXI-lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              aw_valid, aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [2:0]        aw_prot;
  logic              w_valid, w_ready;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic              b_valid, b_ready;
  logic [1:0]        b_resp;
  logic              ar_valid, ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [2:0]        ar_prot;
  logic              r_valid, r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  modport Master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport Slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/ram_1r1w_be.sv
// Word-wide RAM: one synchronous read port, one byte-enabled write port.
// Reads return the contents from before a same-edge write. No reset: contents
// survive a bus reset.
module ram_1r1w_be #(
  parameter int WORDS     = 16384,
  parameter int AW        = 14,
  parameter     INIT_FILE = ""
)(
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // Registered read plus per-byte write.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    for (int b = 0; b < 4; b++)
      if (we_i && wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axil_ram_slave.sv
// AXI-lite RAM target. Independent write (collect AW/W, then B) and read
// (AR, then R one cycle later) FSMs in front of a 1R1W byte-enable RAM.
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24,
  parameter int MEM_WORDS  = 16384,
  parameter     INIT_FILE  = ""
)(
  input  logic  clk,
  input  logic  rst,
  axil_if.Slave ram_axil_bus
);
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // If the decoded space fits in the memory, nothing is ever out of range.
  localparam bit               ALL_IN    = (MEM_WORDS >= (1 << IDX_W));
  localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(MEM_WORDS);

  function automatic logic oor(input logic [IDX_W-1:0] idx);
    return !ALL_IN && (idx >= IDX_LIMIT);
  endfunction

  wr_state_e        wr_state_q, wr_state_d;
  rd_state_e        rd_state_q, rd_state_d;
  logic             rdy_en_q;
  logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic [31:0]      w_data_q, w_data_d;
  logic [3:0]       w_strb_q, w_strb_d;
  logic [1:0]       b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic             rd_oor_q, rd_oor_d;

  logic             aw_fire, w_fire, b_fire, ar_fire, r_fire, commit, wr_oor;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [31:0]      wr_data, ram_rdata;
  logic [3:0]       wr_strb;
  logic             unused_bits;

  // Byte lanes and protection bits carry no meaning for this target.
  assign unused_bits = ^{ram_axil_bus.aw_addr, ram_axil_bus.ar_addr,
                         ram_axil_bus.aw_prot, ram_axil_bus.ar_prot};

  // Readies come from registered state only; rdy_en_q keeps them low until
  // the first edge after reset releases.
  assign ram_axil_bus.aw_ready = rdy_en_q && (wr_state_q == WR_COLLECT) && !aw_held_q;
  assign ram_axil_bus.w_ready  = rdy_en_q && (wr_state_q == WR_COLLECT) && !w_held_q;
  assign ram_axil_bus.ar_ready = rdy_en_q && ((rd_state_q == RD_IDLE) || ram_axil_bus.r_ready);
  assign ram_axil_bus.b_valid  = (wr_state_q == WR_RESP);
  assign ram_axil_bus.b_resp   = b_resp_q;
  assign ram_axil_bus.r_valid  = (rd_state_q == RD_VALID);
  assign ram_axil_bus.r_resp   = r_resp_q;
  assign ram_axil_bus.r_data   = (ram_axil_bus.r_valid && !rd_oor_q) ? ram_rdata : '0;

  assign aw_fire = ram_axil_bus.aw_valid && ram_axil_bus.aw_ready;
  assign w_fire  = ram_axil_bus.w_valid  && ram_axil_bus.w_ready;
  assign b_fire  = ram_axil_bus.b_valid  && ram_axil_bus.b_ready;
  assign ar_fire = ram_axil_bus.ar_valid && ram_axil_bus.ar_ready;
  assign r_fire  = ram_axil_bus.r_valid  && ram_axil_bus.r_ready;

  // A held beat wins over the live bus; otherwise the beat handshaking now.
  assign wr_idx  = aw_held_q ? aw_idx_q : ram_axil_bus.aw_addr[ADDR_WIDTH-1:2];
  assign wr_data = w_held_q  ? w_data_q : ram_axil_bus.w_data;
  assign wr_strb = w_held_q  ? w_strb_q : ram_axil_bus.w_strb;
  assign wr_oor  = oor(wr_idx);
  assign commit  = (wr_state_q == WR_COLLECT) && (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign rd_idx  = ram_axil_bus.ar_addr[ADDR_WIDTH-1:2];

  // Write FSM: fill holders, commit once both are present, then present B.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    b_resp_d   = b_resp_q;
    if (aw_fire) begin
      aw_held_d = 1'b1;
      aw_idx_d  = ram_axil_bus.aw_addr[ADDR_WIDTH-1:2];
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      w_data_d = ram_axil_bus.w_data;
      w_strb_d = ram_axil_bus.w_strb;
    end
    case (wr_state_q)
      WR_COLLECT: if (commit) begin
        wr_state_d = WR_RESP;
        b_resp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
      end
      WR_RESP: if (b_fire) begin
        wr_state_d = WR_COLLECT;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
      end
      default: wr_state_d = WR_COLLECT;
    endcase
  end

  // Read FSM: a new AR while R drains keeps RD_VALID for back-to-back beats.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_oor_d   = rd_oor_q;
    r_resp_d   = r_resp_q;
    if (ar_fire) begin
      rd_state_d = RD_VALID;
      rd_oor_d   = oor(rd_idx);
      r_resp_d   = oor(rd_idx) ? RESP_SLVERR : RESP_OKAY;
    end else if (r_fire) begin
      rd_state_d = RD_IDLE;
    end
  end

  // State and holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_COLLECT;
      rd_state_q <= RD_IDLE;
      rdy_en_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_resp_q   <= RESP_OKAY;
      r_resp_q   <= RESP_OKAY;
      rd_oor_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      rdy_en_q   <= 1'b1;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      b_resp_q   <= b_resp_d;
      r_resp_q   <= r_resp_d;
      rd_oor_q   <= rd_oor_d;
    end
  end

  ram_1r1w_be #(
    .WORDS(MEM_WORDS), .AW(MEM_AW), .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (commit && !wr_oor),
    .waddr_i(wr_idx[MEM_AW-1:0]),
    .wdata_i(wr_data),
    .wstrb_i(wr_strb),
    .re_i   (ar_fire),
    .raddr_i(rd_idx[MEM_AW-1:0]),
    .rdata_o(ram_rdata)
  );
endmodule

// File: tb/tb_axil_ram_slave.sv
// Scoreboard bench for axil_ram_slave: expected R/B beats are queued when
// requests are issued and checked as the DUT hands them over.
module tb_axil_ram_slave;
  import axil_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axil_if #(.ADDR_W(24), .DATA_W(32)) bus ();

  axil_ram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(24), .MEM_WORDS(16384), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .ram_axil_bus(bus)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [31:0] model [int];
  rexp_t       mon_e;
  logic [1:0]  mon_b;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int idx);
    return model.exists(idx) ? model[idx] : 32'h0;
  endfunction

  function automatic bit is_oor(input logic [23:0] a);
    return int'(a[23:2]) >= 16384;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshakes complete at the posedge after the negedge where valid&&ready.
  always @(negedge clk) begin
    if (!rst && bus.r_valid && bus.r_ready) begin
      if (rq.size() == 0) chk("r_unexpected", 32'(1), 32'(0));
      else begin
        mon_e = rq.pop_front();
        chk("r_data", bus.r_data, mon_e.data);
        chk("r_resp", 32'(bus.r_resp), 32'(mon_e.resp));
      end
    end
    if (!rst && bus.b_valid && bus.b_ready) begin
      if (bq.size() == 0) chk("b_unexpected", 32'(1), 32'(0));
      else begin
        mon_b = bq.pop_front();
        chk("b_resp", 32'(bus.b_resp), 32'(mon_b));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Write with independent AW/W start delays; called and returns at posedge+1.
  task automatic axi_write(input logic [23:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input bit hold_b);
    bit aw_pend = 1'b1, w_pend = 1'b1, hs_aw, hs_w;
    int cnt = 0;
    logic [31:0] w;
    if (!hold_b) bq.push_back(is_oor(addr) ? RESP_SLVERR : RESP_OKAY);
    bus.aw_addr = addr; bus.w_data = data; bus.w_strb = strb; bus.b_ready = !hold_b;
    while ((aw_pend || w_pend) && cnt < 50) begin
      bus.aw_valid = aw_pend && (cnt >= aw_dly);
      bus.w_valid  = w_pend && (cnt >= w_dly);
      @(negedge clk);
      hs_aw = bus.aw_valid && bus.aw_ready;
      hs_w  = bus.w_valid && bus.w_ready;
      step();
      if (hs_aw) aw_pend = 1'b0;
      if (hs_w)  w_pend  = 1'b0;
      cnt++;
    end
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk("wr_timeout", 32'(aw_pend || w_pend), 32'(0));
    if (!is_oor(addr)) begin
      w = mword(int'(addr[23:2]));
      for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
      model[int'(addr[23:2])] = w;
    end
    @(negedge clk);
    chk("b_valid_lat", 32'(bus.b_valid), 32'(1));
    chk("aw_ready_in_resp", 32'(bus.aw_ready), 32'(0));
    chk("w_ready_in_resp", 32'(bus.w_ready), 32'(0));
    step();
    if (!hold_b) begin
      bus.b_ready = 1'b0;
      @(negedge clk);
      chk("aw_ready_after_b", 32'(bus.aw_ready), 32'(1));
      chk("w_ready_after_b", 32'(bus.w_ready), 32'(1));
      step();
    end
  endtask

  // Single read with r_ready high; checks one-cycle latency.
  task automatic axi_read(input logic [23:0] addr);
    rexp_t e;
    bit hs = 1'b0;
    int cnt = 0;
    e.data = is_oor(addr) ? 32'h0 : mword(int'(addr[23:2]));
    e.resp = is_oor(addr) ? RESP_SLVERR : RESP_OKAY;
    rq.push_back(e);
    bus.ar_addr = addr; bus.ar_valid = 1'b1; bus.r_ready = 1'b1;
    while (!hs && cnt < 50) begin
      @(negedge clk);
      hs = bus.ar_valid && bus.ar_ready;
      step();
      cnt++;
    end
    bus.ar_valid = 1'b0;
    chk("rd_timeout", 32'(hs), 32'(1));
    @(negedge clk);
    chk("r_lat", 32'(bus.r_valid), 32'(1));
    step();
  endtask

  initial begin
    rexp_t e;
    logic [23:0] b2b [4];
    b2b[0] = 24'h10; b2b[1] = 24'h14; b2b[2] = 24'h10; b2b[3] = 24'h14;
    bus.aw_valid = 0; bus.w_valid = 0; bus.ar_valid = 0; bus.b_ready = 0; bus.r_ready = 0;
    bus.aw_addr = '0; bus.ar_addr = '0; bus.w_data = '0; bus.w_strb = '0;
    bus.aw_prot = '0; bus.ar_prot = '0;
    #1 rst = 1'b1;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_aw_ready", 32'(bus.aw_ready), 32'(0));
    chk("rst_w_ready", 32'(bus.w_ready), 32'(0));
    chk("rst_ar_ready", 32'(bus.ar_ready), 32'(0));
    chk("rst_b_valid", 32'(bus.b_valid), 32'(0));
    chk("rst_r_valid", 32'(bus.r_valid), 32'(0));
    chk("rst_b_resp", 32'(bus.b_resp), 32'(0));
    chk("rst_r_resp", 32'(bus.r_resp), 32'(0));
    chk("rst_r_data", bus.r_data, 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_before_edge", 32'(bus.aw_ready), 32'(0));
    step();
    @(negedge clk);
    chk("rdy_aw_after_rst", 32'(bus.aw_ready), 32'(1));
    chk("rdy_w_after_rst", 32'(bus.w_ready), 32'(1));
    chk("rdy_ar_after_rst", 32'(bus.ar_ready), 32'(1));
    step();

    // Same-cycle AW+W, then read back.
    axi_write(24'h000010, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0);
    axi_read(24'h000010);

    // W three cycles ahead of AW, partial strobes.
    axi_write(24'h000014, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b0);
    axi_write(24'h000014, 32'h11223344, 4'b0101, 3, 0, 1'b0);
    chk("merge_model", mword(5), 32'hFF22FF44);
    axi_read(24'h000014);

    // R backpressure for 5 cycles.
    e.data = 32'hDEADBEEF; e.resp = RESP_OKAY; rq.push_back(e);
    bus.r_ready = 1'b0; bus.ar_addr = 24'h10; bus.ar_valid = 1'b1;
    @(negedge clk);
    chk("bp_ar_ready_idle", 32'(bus.ar_ready), 32'(1));
    step();
    bus.ar_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_r_valid", 32'(bus.r_valid), 32'(1));
      chk("bp_r_data", bus.r_data, 32'hDEADBEEF);
      chk("bp_ar_ready", 32'(bus.ar_ready), 32'(0));
      step();
    end
    bus.r_ready = 1'b1;
    step();

    // Four back-to-back reads.
    for (int i = 0; i < 4; i++) begin
      e.data = mword(int'(b2b[i][23:2])); e.resp = RESP_OKAY; rq.push_back(e);
      bus.ar_addr = b2b[i]; bus.ar_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ar_ready", 32'(bus.ar_ready), 32'(1));
      if (i > 0) chk("b2b_r_valid", 32'(bus.r_valid), 32'(1));
      step();
    end
    bus.ar_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last_beat", 32'(bus.r_valid), 32'(1));
    step();
    @(negedge clk);
    chk("b2b_drained", 32'(bus.r_valid), 32'(0));
    step();

    // Out-of-range write must not alias onto word 0.
    axi_write(24'h000000, 32'hCAFEF00D, 4'hF, 0, 0, 1'b0);
    axi_write(24'h010000, 32'h12345678, 4'hF, 0, 0, 1'b0);
    axi_read(24'h000000);
    axi_read(24'h010000);

    // Byte strobes all zero leave memory alone.
    axi_write(24'h000010, 32'h00000000, 4'h0, 0, 0, 1'b0);
    axi_read(24'h000010);

    // Same-cycle read and write of word 0x20.
    axi_write(24'h000080, 32'hA5A5A5A5, 4'hF, 0, 0, 1'b0);
    e.data = 32'hA5A5A5A5; e.resp = RESP_OKAY; rq.push_back(e);
    bq.push_back(RESP_OKAY);
    bus.aw_addr = 24'h80; bus.w_data = 32'h5A5A5A5A; bus.w_strb = 4'hF; bus.ar_addr = 24'h80;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
    bus.b_ready = 1'b1; bus.r_ready = 1'b1;
    @(negedge clk);
    chk("rw_aw_ready", 32'(bus.aw_ready), 32'(1));
    chk("rw_w_ready", 32'(bus.w_ready), 32'(1));
    chk("rw_ar_ready", 32'(bus.ar_ready), 32'(1));
    step();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    model[32'h20] = 32'h5A5A5A5A;
    @(negedge clk);
    chk("rw_r_valid", 32'(bus.r_valid), 32'(1));
    chk("rw_b_valid", 32'(bus.b_valid), 32'(1));
    step();
    bus.b_ready = 1'b0;
    axi_read(24'h000080);

    // Reset while B is pending.
    axi_write(24'h000040, 32'h0BADCAFE, 4'hF, 0, 0, 1'b1);
    @(negedge clk);
    chk("pre_rst_b_held", 32'(bus.b_valid), 32'(1));
    step();
    #1 rst = 1'b1;
    #1;
    chk("rst_async_b_valid", 32'(bus.b_valid), 32'(0));
    chk("rst_async_aw_ready", 32'(bus.aw_ready), 32'(0));
    bus.b_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale_b", 32'(bus.b_valid), 32'(0));
      step();
    end
    bus.b_ready = 1'b0;
    axi_read(24'h000040);

    step();
    chk("rq_empty", 32'(rq.size()), 32'(0));
    chk("bq_empty", 32'(bq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
